display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_pkg.sv | 31 +++
 rtl/display_scan_ctrl_seg7_decode.sv | 31 +++
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 tb/tb_display_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | display_scan_ctrl_pkg : shared types and segment constants      |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package display_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int unsigned DEF_REFRESH_DIV = 100000;
  localparam int unsigned DEF_BLANK_CYC   = 2000;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_seg7_decode.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg7_decode : BCD to active-low 7-segment, non-BCD shows a dash |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module seg7_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | display_scan_ctrl : 4-digit multiplexed 7-seg scanner with      |
// | frame-synchronous double-buffered value update                  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      staged, shadow;
  logic [15:0]      shadow_shift;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;
  logic             lead_zero;
  logic             frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt == SLOT_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  assign frame_end  = (state == ST_DRIVE) && (cnt == SLOT_LAST) && (idx == 2'd3);
  assign frame_done = frame_end;

  // Digit idx lands in the low nibble; the remaining bits are the digits above it.
  assign shadow_shift = shadow >> {idx, 2'b00};
  assign lead_zero    = blank_lz && (idx != 2'd0) && (shadow_shift == 16'h0000);

  seg7_decode u_dec (
    .bcd (shadow_shift[3:0]),
    .seg (dec_seg)
  );

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    if (state == ST_DRIVE) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = lead_zero ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  // A load on the boundary edge commits the old staged value and stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      staged  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (load) staged <= value;
      if (frame_end && pending) shadow <= staged;
      if (load) pending <= 1'b1;
      else if (frame_end) pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_display_scan_ctrl : scoreboard bench, REFRESH_DIV=8 BLANK=2  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mon_prev = 4'b1111;

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Pops one expectation each time a digit starts being driven.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (an != 4'b1111 && mon_prev == 4'b1111) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_digit: got an=%b seg=%b with no expectation", an, seg);
        end else begin
          e = exp_q.pop_front();
          check("digit_an", 16'(an), 16'(e.an));
          check("digit_seg", 16'(seg), 16'(e.seg));
        end
      end else if (an == 4'b1111 && mon_prev != 4'b1111) begin
        check("blank_seg", 16'(seg), 16'h007f);
      end
      mon_prev = an;
    end
  end

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back('{an: 4'b1110, seg: s0});
    exp_q.push_back('{an: 4'b1101, seg: s1});
    exp_q.push_back('{an: 4'b1011, seg: s2});
    exp_q.push_back('{an: 4'b0111, seg: s3});
  endtask

  task automatic wait_fd();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got none expected pulse within 100 cycles");
    end
  endtask

  task automatic release_and_time();
    int k = 0;
    rst = 1'b0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (an != 4'b1111) k = i;
    end
    check("start_latency", 16'(k), 16'd3);
  endtask

  task automatic load_mid(input logic [15:0] v);
    repeat (5) @(negedge clk);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load = 1'b0;
    check("pending_after_load", 16'(pending), 16'd1);
  endtask

  initial begin
    bit seen;
    // Frame 0: shadow is zero
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    repeat (3) @(negedge clk);
    check("reset_an", 16'(an), 16'h000f);
    check("reset_seg", 16'(seg), 16'h007f);
    check("reset_pending", 16'(pending), 16'd0);
    check("reset_frame_done", 16'(frame_done), 16'd0);
    @(negedge clk);
    release_and_time();

    wait_fd();
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    @(negedge clk);
    check("frame_done_pulse", 16'(frame_done), 16'd0);
    load_mid(16'h1234);

    wait_fd();
    push_frame(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    @(negedge clk);
    check("pending_after_commit", 16'(pending), 16'd0);
    blank_lz = 1'b1;
    load_mid(16'h0070);

    wait_fd();
    push_frame(7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111);
    @(negedge clk);
    load_mid(16'h00AF);

    wait_fd();
    push_frame(7'b0111111, 7'b0111111, 7'b1111111, 7'b1111111);
    @(negedge clk);
    load_mid(16'h2222);

    // Load on the boundary cycle: old staged value commits, pending stays set
    wait_fd();
    push_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
    load  = 1'b1;
    value = 16'h1111;
    @(negedge clk);
    load = 1'b0;
    check("pending_boundary_load", 16'(pending), 16'd1);

    wait_fd();
    push_frame(7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);
    @(negedge clk);
    check("pending_second_commit", 16'(pending), 16'd0);
    load_mid(16'h5555);

    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (an == 4'b1011) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL idx2_timeout: got none expected an=1011 within 100 cycles");
    end
    @(negedge clk);
    exp_q.delete();
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    check("midrst_an", 16'(an), 16'h000f);
    check("midrst_seg", 16'(seg), 16'h007f);
    check("midrst_pending", 16'(pending), 16'd0);

    // Shadow cleared and blanking on: only digit 0 lit
    push_frame(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
    release_and_time();
    wait_fd();
    push_frame(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
    @(negedge clk);
    check("pending_after_rst_frame", 16'(pending), 16'd0);
    wait_fd();
    repeat (2) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
